// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-stated data memory for the core's load/store port.
// Accepts one request in IDLE, counts WAIT_STATES cycles in WAIT, then commits
// the store (or latches the read word) and holds the response in RESP until
// the requester takes it.
// Optional feature: define DMEM_ERR_CHECK_EN to enable alignment and range
// checking that drives rsp_error; without it the word index wraps and
// rsp_error is tied low.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] SZ_READ = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_error_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept;
  logic          complete;
  logic [1:0]    cur_size;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] cur_idx;
  logic [3:0]    be_d;
  logic [31:0]   lane_d;
  logic          err_d;
  logic [31:0]   rdata_d;

  assign accept = (state_q == S_IDLE) && req_ready_q && req_valid;

  // The access completes when the counter runs out, or at acceptance when
  // there are no wait states at all.
  assign complete = (accept && (WAIT_STATES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));

  // With zero wait states the access completes on the accepting edge, so the
  // live request is used; otherwise the frozen captured copy is.
  assign cur_size  = (state_q == S_IDLE) ? req_size  : size_q;
  assign cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign cur_idx   = cur_addr[AW+1:2];

  // Byte-lane enables and lane-replicated store data for the access type.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    be_d   = 4'b0000;
    lane_d = cur_wdata;
    case (cur_size)
      SZ_BYTE: begin
        be_d   = 4'b0001 << cur_addr[1:0];
        lane_d = {4{cur_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_d   = cur_addr[1] ? 4'b1100 : 4'b0011;
        lane_d = {2{cur_wdata[15:0]}};
      end
      SZ_WORD: be_d = 4'b1111;
      default: be_d = 4'b0000;
    endcase
  end

`ifdef DMEM_ERR_CHECK_EN
  // Reject misaligned half/word accesses and word indices beyond the array.
  always_comb begin
    err_d = 1'b0;
    if ((cur_size == SZ_HALF) && cur_addr[0]) err_d = 1'b1;
    if (((cur_size == SZ_READ) || (cur_size == SZ_WORD)) && (cur_addr[1:0] != 2'b00))
      err_d = 1'b1;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) err_d = 1'b1;
  end
`else
  // Without checking, the index wraps, so the upper address bits are don't-care.
  logic unused_addr_hi;
  assign err_d          = 1'b0;
  assign unused_addr_hi = ^cur_addr[31:AW+2];
`endif

  assign rdata_d = ((cur_size == SZ_READ) && !err_d) ? mem_q[cur_idx] : 32'h0;

  // Commit the enabled byte lanes of an accepted, error-free store.
  // NOTE: the array is deliberately not reset; a RAM keeps its contents.
  always_ff @(posedge clock) begin
    if (complete && !err_d) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[cur_idx][8*b +: 8] <= lane_d[8*b +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      size_q      <= 2'b00;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      if (complete) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rdata_d;
        rsp_error_q <= err_d;
      end
      case (state_q)
        S_IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (req_valid) begin
            size_q      <= req_size;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= 4'(WAIT_STATES);
            req_ready_q <= 1'b0;
            state_q     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three responder instances (WAIT_STATES 1, 4, 0) share
// one stimulus bus; only the selected instance is out of reset and observed.
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DEPTH = 64;
`ifdef DMEM_ERR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  localparam logic [1:0] RD = 2'b00, SB = 2'b01, SH = 2'b10, SW = 2'b11;

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    int          hold;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        req_valid, rsp_ready;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  int          sel;

  logic        rstn_w [3];
  logic        rdy    [3];
  logic        vld    [3];
  logic        er     [3];
  logic [31:0] rd     [3];
  logic        rdy_m, vld_m, er_m;
  logic [31:0] rd_m;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [3][DEPTH];

  always #5 clock = ~clock;

  assign rstn_w[0] = rst_n && (sel == 0);
  assign rstn_w[1] = rst_n && (sel == 1);
  assign rstn_w[2] = rst_n && (sel == 2);

  always_comb begin
    rdy_m = rdy[sel];
    vld_m = vld[sel];
    er_m  = er[sel];
    rd_m  = rd[sel];
  end

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
    .clock(clock), .reset_n(rstn_w[0]), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[0]), .rsp_ready(rsp_ready), .rsp_rdata(rd[0]), .rsp_error(er[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(4)) u_ws4 (
    .clock(clock), .reset_n(rstn_w[1]), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[1]), .rsp_ready(rsp_ready), .rsp_rdata(rd[1]), .rsp_error(er[1]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset_n(rstn_w[2]), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld[2]), .rsp_ready(rsp_ready), .rsp_rdata(rd[2]), .rsp_error(er[2]));

  function automatic int ws_of(input int k);
    case (k)
      0: return 1;
      1: return 4;
      default: return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference model: access rules computed directly from the address arithmetic.
  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    if (!CHK) return 1'b0;
    if (sz == SH && (a % 2) != 0) return 1'b1;
    if ((sz == RD || sz == SW) && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= DEPTH) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] r;
    int off;
    r = old;
    case (sz)
      SB: begin off = int'(a % 4);       r[8*off +: 8]   = wd[7:0];  end
      SH: begin off = int'((a / 2) % 2); r[16*off +: 16] = wd[15:0]; end
      SW: r = wd;
      default: ;
    endcase
    return r;
  endfunction

  // One full transaction starting #1 after an edge; returns the response and
  // leaves the bench #1 after the handshake edge.
  task automatic do_txn(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int hold, output logic [31:0] r_rd, output logic r_er);
    int n;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_size = sz; req_addr = a; req_wdata = wd;
    n = 0;
    while (!rdy_m && n < 20) begin @(posedge clock); #1; n++; end
    if (!rdy_m) begin
      check("accept_timeout", rdy_m, 1'b1);
      req_valid = 1'b0; r_rd = 32'h0; r_er = 1'b0;
      return;
    end
    @(posedge clock); #1;
    // Scramble the bus after acceptance: captured fields must stay frozen.
    req_valid = 1'b0; req_size = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
    n = 0;
    while (!vld_m && n < 40) begin
      check("ready_low_wait", rdy_m, 1'b0);
      rsp_ready = 1'($urandom_range(0, 1));
      req_valid = 1'($urandom_range(0, 1));
      @(posedge clock); #1; n++;
    end
    rsp_ready = 1'b0;
    check("latency", n, ws_of(sel));
    r_rd = rd_m; r_er = er_m;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
      check("hold_valid", vld_m, 1'b1);
      check("hold_rdata", rd_m, r_rd);
      check("hold_ready_low", rdy_m, 1'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    check("valid_drop", vld_m, 1'b0);
    check("ready_after_hs", rdy_m, 1'b1);
  endtask

  task automatic select_dut(input int k);
    sel = k;
    repeat (2) @(posedge clock);
    #1;
    check("ready_after_release", rdy_m, 1'b1);
  endtask

  task automatic random_phase(input int k, input int n_ops);
    logic [31:0] r_rd, a, wd, exp_rd, v;
    logic        r_er, exp_err;
    logic [1:0]  sz;
    int          idx, hold;
    for (int w = 0; w < DEPTH; w++) begin
      v = $urandom;
      do_txn(SW, 32'(w * 4), v, 0, r_rd, r_er);
      mdl[k][w] = v;
    end
    for (int i = 0; i < n_ops; i++) begin
      sz   = 2'($urandom_range(0, 3));
      a    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 8 * DEPTH - 1));
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      do_txn(sz, a, wd, hold, r_rd, r_er);
      exp_err = model_err(sz, a);
      idx     = model_idx(a);
      exp_rd  = (sz == RD && !exp_err) ? mdl[k][idx] : 32'h0;
      check("rnd_rdata", r_rd, exp_rd);
      check("rnd_error", r_er, exp_err);
      if (sz != RD && !exp_err) mdl[k][idx] = model_store(mdl[k][idx], sz, a, wd);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                              input int hold, input logic [31:0] exp_rd, input logic exp_err);
    vec_t v;
    v.sz = sz; v.addr = a; v.wd = wd; v.hold = hold; v.exp_rd = exp_rd; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] r_rd;
    logic        r_er;
    int          n, acc;

    vecs.push_back(mk(SW, 32'h00,  32'h0BADC0DE, 0, 32'h0, 1'b0));
    vecs.push_back(mk(SW, 32'h04,  32'h44444444, 0, 32'h0, 1'b0));
    vecs.push_back(mk(SW, 32'h10,  32'hDEADBEEF, 0, 32'h0, 1'b0));
    vecs.push_back(mk(RD, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(SW, 32'h20,  32'h11223344, 0, 32'h0, 1'b0));
    vecs.push_back(mk(SB, 32'h21,  32'h123456AA, 0, 32'h0, 1'b0));
    vecs.push_back(mk(SH, 32'h22,  32'h9999BEEF, 0, 32'h0, 1'b0));
    vecs.push_back(mk(RD, 32'h20,  32'h0,        5, 32'hBEEFAA44, 1'b0));
    vecs.push_back(mk(SW, 32'h13,  32'hCAFEF00D, 0, 32'h0, CHK));
    vecs.push_back(mk(RD, 32'h10,  32'h0,        0, CHK ? 32'hDEADBEEF : 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(RD, 32'h100, 32'h0,        0, CHK ? 32'h0 : 32'h0BADC0DE, CHK));
    vecs.push_back(mk(SW, 32'h104, 32'h9ABCDEF0, 0, 32'h0, CHK));
    vecs.push_back(mk(RD, 32'h04,  32'h0,        0, CHK ? 32'h44444444 : 32'h9ABCDEF0, 1'b0));
    vecs.push_back(mk(SW, 32'h30,  32'h00000000, 0, 32'h0, 1'b0));
    vecs.push_back(mk(SH, 32'h31,  32'h5A5A1234, 0, 32'h0, CHK));
    vecs.push_back(mk(SB, 32'h33,  32'h00000077, 0, 32'h0, 1'b0));
    vecs.push_back(mk(RD, 32'h30,  32'h0,        1, CHK ? 32'h77000000 : 32'h77001234, 1'b0));
    vecs.push_back(mk(RD, 32'h22,  32'h0,        0, CHK ? 32'h0 : 32'hBEEFAA44, CHK));
    vecs.push_back(mk(SB, 32'h102, 32'h000000EE, 0, 32'h0, CHK));
    vecs.push_back(mk(RD, 32'h00,  32'h0,        0, CHK ? 32'h0BADC0DE : 32'h0BEEC0DE, 1'b0));

    sel = 0; rst_n = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0; req_size = 2'b00; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ready", rdy_m, 1'b0);
    check("reset_valid", vld_m, 1'b0);
    check("reset_rdata", rd_m, 32'h0);
    check("reset_error", er_m, 1'b0);
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("ready_after_reset", rdy_m, 1'b1);

    // Directed table on the WAIT_STATES=1 instance.
    for (int i = 0; i < vecs.size(); i++) begin
      do_txn(vecs[i].sz, vecs[i].addr, vecs[i].wd, vecs[i].hold, r_rd, r_er);
      check($sformatf("vec%0d_rdata", i), r_rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_error", i), r_er, vecs[i].exp_err);
    end
    random_phase(0, 80);

    // WAIT_STATES=4: reset during WAIT discards the pending store.
    select_dut(1);
    do_txn(SW, 32'h40, 32'h12345678, 0, r_rd, r_er);
    req_valid = 1'b1; req_size = SW; req_addr = 32'h40; req_wdata = 32'h5555AAAA;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    rst_n = 1'b0; #1;
    check("wait_rst_valid", vld_m, 1'b0);
    check("wait_rst_ready", rdy_m, 1'b0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("wait_rst_idle", rdy_m, 1'b1);
    do_txn(RD, 32'h40, 32'h0, 0, r_rd, r_er);
    check("wait_rst_mem", r_rd, 32'h12345678);

    // Reset during RESP drops the response but keeps the committed store.
    req_valid = 1'b1; req_size = SW; req_addr = 32'h44; req_wdata = 32'h0F0F0F0F;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (!vld_m && n < 20) begin @(posedge clock); #1; n++; end
    check("resp_reached", vld_m, 1'b1);
    rst_n = 1'b0; #1;
    check("resp_rst_valid", vld_m, 1'b0);
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(posedge clock); #1;
    check("resp_rst_idle", rdy_m, 1'b1);
    do_txn(RD, 32'h44, 32'h0, 0, r_rd, r_er);
    check("resp_rst_mem", r_rd, 32'h0F0F0F0F);

    // WAIT_STATES=0: random traffic, then back-to-back throughput.
    select_dut(2);
    random_phase(2, 60);
    req_valid = 1'b1; req_size = RD; req_addr = 32'h0; rsp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (rdy_m) acc++;
      @(posedge clock); #1;
    end
    req_valid = 1'b0;
    @(posedge clock); #1;
    rsp_ready = 1'b0;
    check("ws0_accepts_in_20", acc, 10);
    check("ws0_idle_after", rdy_m, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
